decoder_rr_arbiter: RTL

- Four-requester round-robin arbiter that shares one decoded resource, such as a shared bus or a register-file write port.
- Its encoded outputs (address[1:0], enable) drive the 2-to-4 decoder directly.
- A registered one-hot grant bus, equal to what the decoder would produce, is also provided.
- A hold counter bounds how long one requester can own the resource under contention.

---
 rtl/decoder_rr_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/decoder_rr_arbiter.sv
// Four-requester round-robin arbiter with encoded (address/enable) and one-hot grant outputs.
// A hold counter bounds ownership under contention; every output is registered.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic       enable,
  output logic [1:0] address,
  output logic [3:0] grant,
  output logic       busy
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15 || (1 << CW) <= MAX_HOLD) begin : g_bad_param
    $error("decoder_rr_arbiter: MAX_HOLD must be 1..15 and fit in CW bits");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
  localparam logic [CW-1:0] ONE        = CW'(1);

  state_t        state;
  logic [CW-1:0] count;
  logic [1:0]    ptr;

  logic [3:0]    others;
  logic [1:0]    win_idle;
  logic [1:0]    win_other;

  // First asserted line at or after (from+1), wrapping; 'from' itself is visited last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = from;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = from + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

  always_comb begin
    others    = req & ~onehot(address);
    win_idle  = rr_pick(req, ptr);
    win_other = rr_pick(others, address);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      ptr     <= 2'd3;
      enable  <= 1'b0;
      busy    <= 1'b0;
      address <= 2'd0;
      grant   <= 4'b0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state   <= GRANT;
            address <= win_idle;
            ptr     <= win_idle;
            grant   <= onehot(win_idle);
            enable  <= 1'b1;
            busy    <= 1'b1;
            count   <= ONE;
          end
        end
        GRANT: begin
          if (!req[address] || count == HOLD_LIMIT) begin
            if (|others) begin
              // Same-edge handover: the owner is searched last, so it drops to lowest priority.
              address <= win_other;
              ptr     <= win_other;
              grant   <= onehot(win_other);
              count   <= ONE;
            end else if (!req[address]) begin
              state  <= IDLE;
              enable <= 1'b0;
              busy   <= 1'b0;
              grant  <= 4'b0000;
              count  <= '0;
            end else begin
              count <= ONE;
            end
          end else begin
            count <= count + ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
